// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring divide,
// one bit per clock, with start/busy/done handshake, cancel, and MTHI/MTLO writes.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [2:0] OpMult = 3'd0;
  localparam logic [2:0] OpDiv  = 3'd2;
  localparam logic [2:0] OpMthi = 3'd4;
  localparam logic [2:0] OpMtlo = 3'd5;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dbz_q, dbz_d;

  logic               signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    signed_op = (op == OpMult) || (op == OpDiv);
    sign_a    = signed_op & a[WIDTH-1];
    sign_b    = signed_op & b[WIDTH-1];
    mag_a     = sign_a ? -a : a;
    mag_b     = sign_b ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : {WIDTH{1'b0}})};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};

    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!op[2]) begin
            state_d   = StCalc;
            cnt_d     = CntW'(WIDTH - 1);
            is_div_d  = op[1];
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            m_d       = op[1] ? mag_b : mag_a;
          end else if (op == OpMthi) begin
            hi_d = a;
          end else if (op == OpMtlo) begin
            lo_d = a;
          end
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the difference only when it did not borrow
            acc_d = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = StFinish;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (m_q == '0) begin
            hi_d  = '0;
            lo_d  = '0;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule
